// File: rtl/iir_lowpass_mc_if.sv
// Sample-path handshake bundle for the multichannel IIR low-pass filter.
// The master side feeds samples and consumes filtered results.
interface iir_lowpass_mc_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [CW-1:0]           in_chan_i;
    logic signed [WIDTH-1:0] data_i;
    logic [1:0]              mode_i;
    logic                    clear_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [CW-1:0]           out_chan_o;
    logic signed [WIDTH-1:0] data_o;
    logic                    sat_o;

    modport master (
        output in_valid_i, in_chan_i, data_i, mode_i, clear_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_chan_o, data_o, sat_o
    );

    modport slave (
        input  in_valid_i, in_chan_i, data_i, mode_i, clear_i, out_ready_i,
        output in_ready_o, out_valid_o, out_chan_o, data_o, sat_o
    );
endinterface

// File: rtl/iir_lowpass_mc.sv
// First-order IIR y += (x - y) >>> SHIFT, time-multiplexed over CHANNELS,
// with bypass/low-pass/high-pass output select and saturation.
module iir_lowpass_mc #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SHIFT    = 2,
    parameter int FRAC     = 2
) (
    input logic            clk_i,
    input logic            reset_i,
    iir_lowpass_mc_if.slave bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW = WIDTH + FRAC + 1;
    localparam logic [CW:0] CH_N = (CW + 1)'(CHANNELS);
    localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [AW-1:0]    acc_q [CHANNELS];
    logic                    out_valid_q;
    logic [CW-1:0]           out_chan_q;
    logic signed [WIDTH-1:0] data_q;
    logic                    sat_q;

    logic                    in_ready;
    logic                    fire;
    logic                    chan_ok;
    logic                    take;
    logic signed [AW-1:0]    acc_cur;
    logic signed [AW:0]      xs;
    logic signed [AW:0]      diff;
    logic signed [AW-1:0]    acc_nxt;
    logic signed [WIDTH:0]   lp;
    logic signed [WIDTH:0]   hp;
    logic signed [WIDTH:0]   res;
    logic signed [WIDTH-1:0] res_sat;
    logic                    res_clip;

    assign in_ready = ~out_valid_q | bus.out_ready_i;
    assign fire     = bus.in_valid_i & in_ready;
    assign chan_ok  = {1'b0, bus.in_chan_i} < CH_N;
    assign take     = fire & chan_ok;

    always_comb begin
        acc_cur = '0;
        // A same-cycle clear makes this sample start from a zero state.
        if (chan_ok && !bus.clear_i)
            acc_cur = acc_q[bus.in_chan_i];
        xs      = (AW + 1)'(bus.data_i) <<< FRAC;
        diff    = xs - (AW + 1)'(acc_cur);
        acc_nxt = acc_cur + AW'(diff >>> SHIFT);
        lp      = acc_nxt[AW-1:FRAC];
        hp      = (WIDTH + 1)'(bus.data_i) - lp;
        case (bus.mode_i)
            2'd1:    res = lp;
            2'd2:    res = hp;
            default: res = (WIDTH + 1)'(bus.data_i);
        endcase
        res_clip = res[WIDTH] != res[WIDTH-1];
        res_sat  = res[WIDTH-1:0];
        if (res_clip)
            res_sat = res[WIDTH] ? S_MIN : S_MAX;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int c = 0; c < CHANNELS; c++)
                acc_q[c] <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (take && bus.in_chan_i == CW'(c))
                    acc_q[c] <= acc_nxt;
                else if (bus.clear_i)
                    acc_q[c] <= '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            data_q      <= '0;
            sat_q       <= 1'b0;
        end else if (take) begin
            out_valid_q <= 1'b1;
            out_chan_q  <= bus.in_chan_i;
            data_q      <= res_sat;
            sat_q       <= res_clip;
        end else if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_chan_o  = out_chan_q;
    assign bus.data_o      = data_q;
    assign bus.sat_o       = sat_q;
endmodule

// File: tb/tb_iir_lowpass_mc.sv
// Directed bench for iir_lowpass_mc with hand-computed filter outputs.
// Covers step response, isolation, backpressure, saturation, clear, reset.
module tb_iir_lowpass_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    iir_lowpass_mc_if #(.WIDTH(16), .CHANNELS(4)) bus ();

    iir_lowpass_mc #(
        .WIDTH(16), .CHANNELS(4), .SHIFT(2), .FRAC(2)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input int ch, input int d, input int m, input bit clr);
        bus.in_valid_i = 1'b1;
        bus.in_chan_i  = 2'(ch);
        bus.data_i     = 16'(d);
        bus.mode_i     = 2'(m);
        bus.clear_i    = clr;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        bus.clear_i    = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int ch, input int d, input int s);
        check({tag, "_valid"}, int'(bus.out_valid_o), 1);
        check({tag, "_chan"}, int'(bus.out_chan_o), ch);
        check({tag, "_data"}, int'(bus.data_o), d);
        check({tag, "_sat"}, int'(bus.sat_o), s);
    endtask

    task automatic pulse_clear();
        bus.clear_i = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_i = 1'b0;
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_chan_i   = '0;
        bus.data_i      = '0;
        bus.mode_i      = '0;
        bus.clear_i     = 1'b0;
        bus.out_ready_i = 1'b1;

        @(posedge clk);
        #1;
        check("rst_valid", int'(bus.out_valid_o), 0);
        check("rst_data", int'(bus.data_o), 0);
        check("rst_chan", int'(bus.out_chan_o), 0);
        check("rst_sat", int'(bus.sat_o), 0);
        check("rst_ready", int'(bus.in_ready_o), 1);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Step response on ch0, plus a ch1 sample to leave state behind
        send(0, 1000, 1, 1'b0); expect_out("lp1", 0, 250, 0);
        send(0, 1000, 1, 1'b0); expect_out("lp2", 0, 437, 0);
        send(0, 1000, 1, 1'b0); expect_out("lp3", 0, 578, 0);
        send(1, 1000, 1, 1'b0); expect_out("c1a", 1, 250, 0);

        // Clear together with a sample: sample wins for its own channel
        send(0, 1000, 1, 1'b1); expect_out("clr0", 0, 250, 0);
        send(1, 1000, 1, 1'b0); expect_out("clr1", 1, 250, 0);
        send(0, 1000, 1, 1'b0); expect_out("clr0b", 0, 437, 0);

        // High-pass and channel isolation
        pulse_clear();
        send(0, 1000, 2, 1'b0); expect_out("hp1", 0, 750, 0);
        send(1, 0, 1, 1'b0);    expect_out("iso1", 1, 0, 0);
        send(0, 1000, 1, 1'b0); expect_out("iso0", 0, 437, 0);
        send(3, -5, 3, 1'b0);   expect_out("byp3", 3, -5, 0);
        send(3, 77, 0, 1'b0);   expect_out("byp0", 3, 77, 0);
        @(posedge clk);
        #1;
        check("drop_valid", int'(bus.out_valid_o), 0);

        // Backpressure: pending sample must update state exactly once
        pulse_clear();
        send(0, 1000, 1, 1'b0); expect_out("bp0", 0, 250, 0);
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_chan_i   = 2'd0;
        bus.data_i      = 16'sd1000;
        bus.mode_i      = 2'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_ready", int'(bus.in_ready_o), 0);
            expect_out("bp_hold", 0, 250, 0);
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        expect_out("bp1", 0, 437, 0);
        @(posedge clk);
        #1;
        expect_out("bp2", 0, 578, 0);
        bus.in_valid_i = 1'b0;

        // Saturation: settle ch2 near full scale, then a negative step on hp
        pulse_clear();
        for (int i = 0; i < 64; i++)
            send(2, 32767, 1, 1'b0);
        expect_out("sat_lp", 2, 32766, 0);
        send(2, -32768, 2, 1'b0); expect_out("sat_hp", 2, -32768, 1);

        // Reset between edges discards the in-flight output and all state
        send(0, 1000, 1, 1'b0);
        send(0, 1000, 1, 1'b0); expect_out("pre_rst", 0, 437, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(bus.out_valid_o), 0);
        check("mid_rst_data", int'(bus.data_o), 0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        send(0, 1000, 1, 1'b0); expect_out("post_rst", 0, 250, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
